instruction_fetch: RTL and testbench
====================================

INSTRUCTION_FETCH -- requirements
Module: instruction_fetch

Interface
REQ-001 Parameter ADDR_W, default 10, instruction-memory address width.
REQ-002 Parameter DATA_W, default 32, instruction word width.
REQ-003 Parameter HALT_OP, default 6'b111111, opcode in bits [31:26] that stops fetch.
REQ-004 clock  input  1  single clock; all state updates on posedge clock.
REQ-005 reset  input  1  synchronous, active-high reset, sampled on posedge clock.
REQ-006 addy  output  ADDR_W  address driven to the instruction memory, combinationally equal to internal pc.
REQ-007 RAMOuput  input  DATA_W  instruction word returned combinationally by the instruction memory for addy.
REQ-008 stall  input  1  downstream not ready; hold fetch state.
REQ-009 branch_taken  input  1  redirect fetch this cycle.
REQ-010 branch_target  input  ADDR_W  redirect address, valid when branch_taken=1.
REQ-011 instr_out  output  DATA_W  registered IF/ID instruction.
REQ-012 instr_pc  output  ADDR_W  address from which instr_out was fetched.
REQ-013 instr_valid  output  1  instr_out holds a real instruction.
REQ-014 halted  output  1  fetch stopped by HALT_OP.

Function
REQ-015 Priority per cycle SHALL be reset > branch_taken > halted > stall > normal fetch.
REQ-016 Normal fetch: instr_out<=RAMOuput, instr_pc<=pc, instr_valid<=1, pc<=pc+1; one instruction per cycle.
REQ-017 Latency: word at address A SHALL appear on instr_out exactly one cycle after addy=A was presented.
REQ-018 pc increment SHALL be modulo 2^ADDR_W; 1023 wraps to 0 without any flag.
REQ-019 Stall: pc, instr_out, instr_pc, instr_valid SHALL all hold their values.
REQ-020 Branch: pc<=branch_target, instr_out<=0, instr_valid<=0 (one-cycle bubble); overrides a simultaneous stall.
REQ-021 Branch while halted SHALL clear halted and resume fetch at branch_target on the next cycle.
REQ-022 Halt: when normal fetch captures RAMOuput[31:26]==HALT_OP, the halt word SHALL be issued with instr_valid=1, halted<=1, and pc SHALL not advance.
REQ-023 While halted (no branch): pc held, instr_valid<=0 after the halt word, instr_out/instr_pc held.
REQ-024 A halt word present at addy during a stall SHALL not set halted until it is actually captured.
REQ-025 State machine: FETCH (normal/stall/branch) and HALT; FETCH->HALT on REQ-022, HALT->FETCH on branch_taken or reset.

Reset
REQ-026 On reset: pc=0, instr_out=0, instr_pc=0, instr_valid=0, halted=0, state=FETCH.
REQ-027 Reset mid-stall, mid-branch, or while halted SHALL produce the REQ-026 values on the following cycle; the first post-reset fetch is from address 0.

Structure
REQ-028 A shared package SHALL hold ADDR_W, DATA_W, opcode field position [31:26], HALT_OP and NOP (32'b0) constants, for use by instructionMemory and the decoder.
REQ-029 No sub-module is required; the instruction memory is instantiated beside this block, not inside it.

Verification
REQ-030 Reset, memory words 0..3 = distinct non-halt values, no stall -> instr_out shows words 0,1,2,3 on cycles 1..4 after reset, with instr_pc 0..3 and instr_valid=1.
REQ-031 stall=1 for 3 cycles at pc=5 -> outputs frozen for 3 cycles, then word 5 follows with no skip and no duplicate.
REQ-032 branch_taken=1, target=200, at pc=7 with stall=1 -> one bubble (instr_valid=0, instr_out=0), then word 200 with instr_pc=200.
REQ-033 Word 4 opcode=6'b111111 -> word 4 issued valid, halted=1, addy held at 4, instr_valid=0 thereafter; branch to 0 -> halted=0, word 0 fetched next.
REQ-034 Branch to 1022, no stall -> instr_pc sequence 1022, 1023, 0, 1.
REQ-035 Reset asserted while halted and while stalled -> all outputs at REQ-026 values next cycle; fetch restarts at address 0.

Source files
------------

// File: rtl/instruction_fetch_pkg.sv
// Shared fetch/decode constants: bus widths, opcode field location, halt opcode and NOP.
package instruction_fetch_pkg;

  localparam int          IF_ADDR_W  = 10;
  localparam int          IF_DATA_W  = 32;
  localparam int          OPC_HI     = 31;
  localparam int          OPC_LO     = 26;
  localparam logic [5:0]  IF_HALT_OP = 6'b111111;
  localparam logic [31:0] IF_NOP     = 32'b0;

  typedef enum logic {
    S_FETCH = 1'b0,
    S_HALT  = 1'b1
  } if_state_e;

  function automatic logic is_halt_op(input logic [5:0] opc, input logic [5:0] halt_op);
    return opc == halt_op;
  endfunction

endpackage

// File: rtl/instruction_fetch_if.sv
// Fetch-stage bus: instruction-memory address/data, pipeline control in, IF/ID register out.
interface instruction_fetch_if
  import instruction_fetch_pkg::*;
#(
  parameter int ADDR_W = IF_ADDR_W,
  parameter int DATA_W = IF_DATA_W
);

  logic [ADDR_W-1:0] addy;
  logic [DATA_W-1:0] RAMOuput;
  logic              stall;
  logic              branch_taken;
  logic [ADDR_W-1:0] branch_target;
  logic [DATA_W-1:0] instr_out;
  logic [ADDR_W-1:0] instr_pc;
  logic              instr_valid;
  logic              halted;

  modport master (
    output addy, instr_out, instr_pc, instr_valid, halted,
    input  RAMOuput, stall, branch_taken, branch_target
  );

  modport slave (
    input  addy, instr_out, instr_pc, instr_valid, halted,
    output RAMOuput, stall, branch_taken, branch_target
  );

endinterface

// File: rtl/instruction_fetch.sv
// Instruction fetch stage: drives pc to the memory and registers the returned word into IF/ID.
module instruction_fetch
  import instruction_fetch_pkg::*;
#(
  parameter int         ADDR_W  = IF_ADDR_W,
  parameter int         DATA_W  = IF_DATA_W,
  parameter logic [5:0] HALT_OP = IF_HALT_OP
) (
  input logic                 clock,
  input logic                 reset,
  instruction_fetch_if.master bus
);

  if_state_e         state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [ADDR_W-1:0] ipc_q, ipc_d;
  logic [DATA_W-1:0] instr_q, instr_d;
  logic              vld_q, vld_d;
  logic              halt_word;

  assign halt_word = is_halt_op(bus.RAMOuput[OPC_HI:OPC_LO], HALT_OP);

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= S_FETCH;
      pc_q    <= '0;
      ipc_q   <= '0;
      instr_q <= DATA_W'(IF_NOP);
      vld_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      ipc_q   <= ipc_d;
      instr_q <= instr_d;
      vld_q   <= vld_d;
    end
  end

  // Branch beats halt beats stall; a halt word only counts once it is actually captured.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    ipc_d   = ipc_q;
    instr_d = instr_q;
    vld_d   = vld_q;
    if (bus.branch_taken) begin
      state_d = S_FETCH;
      pc_d    = bus.branch_target;
      instr_d = DATA_W'(IF_NOP);
      vld_d   = 1'b0;
    end else if (state_q == S_HALT) begin
      vld_d = 1'b0;
    end else if (!bus.stall) begin
      instr_d = bus.RAMOuput;
      ipc_d   = pc_q;
      vld_d   = 1'b1;
      if (halt_word) begin
        state_d = S_HALT;
      end else begin
        pc_d = pc_q + ADDR_W'(1);
      end
    end
  end

  always_comb begin
    bus.addy        = pc_q;
    bus.instr_out   = instr_q;
    bus.instr_pc    = ipc_q;
    bus.instr_valid = vld_q;
    bus.halted      = (state_q == S_HALT);
  end

endmodule

// File: tb/tb_instruction_fetch.sv
// Scoreboard bench for instruction_fetch with a combinational instruction memory model.
module tb_instruction_fetch;
  import instruction_fetch_pkg::*;

  localparam int AW = 10;
  localparam int DW = 32;

  typedef struct packed {
    logic [DW-1:0] instr;
    logic [AW-1:0] ipc;
    logic          vld;
    logic          hlt;
    logic [AW-1:0] addy;
  } obs_t;

  typedef struct packed {
    obs_t v;
    obs_t m;
  } sb_t;

  logic          clock = 1'b0;
  logic          reset = 1'b1;
  logic [DW-1:0] mem [0:(1<<AW)-1];
  int            checks = 0;
  int            errors = 0;
  sb_t           sb[$];

  instruction_fetch_if #(.ADDR_W(AW), .DATA_W(DW)) ifc ();

  instruction_fetch #(.ADDR_W(AW), .DATA_W(DW), .HALT_OP(IF_HALT_OP)) dut (
    .clock(clock),
    .reset(reset),
    .bus  (ifc)
  );

  always #5 clock = ~clock;

  assign ifc.RAMOuput = mem[ifc.addy];

  function automatic obs_t mk(input logic [DW-1:0] instr, input int ipc, input logic vld,
                              input logic hlt, input int addy);
    return {instr, AW'(ipc), vld, hlt, AW'(addy)};
  endfunction

  // Bubble cycles leave instr_pc unconstrained, so its bits can be masked out.
  function automatic obs_t msk(input bit care_ipc);
    obs_t m;
    m = '1;
    if (!care_ipc) m.ipc = '0;
    return m;
  endfunction

  function automatic obs_t sample();
    return {ifc.instr_out, ifc.instr_pc, ifc.instr_valid, ifc.halted, ifc.addy};
  endfunction

  task automatic drive(input logic r, input logic s, input logic b, input int t);
    reset             = r;
    ifc.stall         = s;
    ifc.branch_taken  = b;
    ifc.branch_target = AW'(t);
  endtask

  task automatic test_reset();
    sb_t e;
    for (int i = 0; i < 2; i++) begin
      drive(1'b1, 1'b0, 1'b0, 0);
      sb.push_back({mk(IF_NOP, 0, 1'b0, 1'b0, 0), msk(1)});
      @(posedge clock); #1;
      e = sb.pop_front(); checks++;
      if (((sample() ^ e.v) & e.m) !== '0) begin
        errors++; $display("FAIL reset[%0d] got=%h exp=%h", i, sample(), e.v);
      end
    end
  endtask

  task automatic test_fetch();
    sb_t e;
    for (int i = 1; i <= 5; i++) begin
      drive(1'b0, 1'b0, 1'b0, 0);
      sb.push_back({mk(mem[i-1], i-1, 1'b1, 1'b0, i), msk(1)});
      @(posedge clock); #1;
      e = sb.pop_front(); checks++;
      if (((sample() ^ e.v) & e.m) !== '0) begin
        errors++; $display("FAIL fetch[%0d] got=%h exp=%h", i, sample(), e.v);
      end
    end
  endtask

  task automatic test_stall();
    sb_t e;
    for (int i = 0; i < 5; i++) begin
      if (i < 3) begin
        drive(1'b0, 1'b1, 1'b0, 0);
        sb.push_back({mk(mem[4], 4, 1'b1, 1'b0, 5), msk(1)});
      end else begin
        drive(1'b0, 1'b0, 1'b0, 0);
        sb.push_back({mk(mem[i+2], i+2, 1'b1, 1'b0, i+3), msk(1)});
      end
      @(posedge clock); #1;
      e = sb.pop_front(); checks++;
      if (((sample() ^ e.v) & e.m) !== '0) begin
        errors++; $display("FAIL stall[%0d] got=%h exp=%h", i, sample(), e.v);
      end
    end
  endtask

  task automatic test_branch_stall();
    sb_t e;
    for (int i = 0; i < 3; i++) begin
      if (i == 0) begin
        drive(1'b0, 1'b1, 1'b1, 200);
        sb.push_back({mk(IF_NOP, 0, 1'b0, 1'b0, 200), msk(0)});
      end else begin
        drive(1'b0, 1'b0, 1'b0, 0);
        sb.push_back({mk(mem[199+i], 199+i, 1'b1, 1'b0, 200+i), msk(1)});
      end
      @(posedge clock); #1;
      e = sb.pop_front(); checks++;
      if (((sample() ^ e.v) & e.m) !== '0) begin
        errors++; $display("FAIL branch[%0d] got=%h exp=%h", i, sample(), e.v);
      end
    end
  endtask

  task automatic test_wrap();
    sb_t e;
    int  p;
    for (int i = 0; i < 5; i++) begin
      if (i == 0) begin
        drive(1'b0, 1'b0, 1'b1, 1022);
        sb.push_back({mk(IF_NOP, 0, 1'b0, 1'b0, 1022), msk(0)});
      end else begin
        drive(1'b0, 1'b0, 1'b0, 0);
        p = (1021 + i) % 1024;
        sb.push_back({mk(mem[p], p, 1'b1, 1'b0, (p + 1) % 1024), msk(1)});
      end
      @(posedge clock); #1;
      e = sb.pop_front(); checks++;
      if (((sample() ^ e.v) & e.m) !== '0) begin
        errors++; $display("FAIL wrap[%0d] got=%h exp=%h", i, sample(), e.v);
      end
    end
  endtask

  task automatic test_halt();
    sb_t e;
    mem[4] = {IF_HALT_OP, 26'h15A5};
    for (int i = 0; i < 12; i++) begin
      case (i)
        0: begin
          drive(1'b1, 1'b0, 1'b0, 0);
          sb.push_back({mk(IF_NOP, 0, 1'b0, 1'b0, 0), msk(1)});
        end
        1, 2, 3, 4: begin
          drive(1'b0, 1'b0, 1'b0, 0);
          sb.push_back({mk(mem[i-1], i-1, 1'b1, 1'b0, i), msk(1)});
        end
        5, 6: begin
          drive(1'b0, 1'b1, 1'b0, 0);
          sb.push_back({mk(mem[3], 3, 1'b1, 1'b0, 4), msk(1)});
        end
        7: begin
          drive(1'b0, 1'b0, 1'b0, 0);
          sb.push_back({mk(mem[4], 4, 1'b1, 1'b1, 4), msk(1)});
        end
        8, 9: begin
          drive(1'b0, (i == 9), 1'b0, 0);
          sb.push_back({mk(mem[4], 4, 1'b0, 1'b1, 4), msk(1)});
        end
        10: begin
          drive(1'b0, 1'b0, 1'b1, 0);
          sb.push_back({mk(IF_NOP, 0, 1'b0, 1'b0, 0), msk(0)});
        end
        default: begin
          drive(1'b0, 1'b0, 1'b0, 0);
          sb.push_back({mk(mem[0], 0, 1'b1, 1'b0, 1), msk(1)});
        end
      endcase
      @(posedge clock); #1;
      e = sb.pop_front(); checks++;
      if (((sample() ^ e.v) & e.m) !== '0) begin
        errors++; $display("FAIL halt[%0d] got=%h exp=%h", i, sample(), e.v);
      end
    end
  endtask

  task automatic test_reset_mid();
    sb_t e;
    for (int i = 0; i < 10; i++) begin
      case (i)
        0, 1, 2: begin
          drive(1'b0, 1'b0, 1'b0, 0);
          sb.push_back({mk(mem[i+1], i+1, 1'b1, 1'b0, i+2), msk(1)});
        end
        3: begin
          drive(1'b0, 1'b0, 1'b0, 0);
          sb.push_back({mk(mem[4], 4, 1'b1, 1'b1, 4), msk(1)});
        end
        4, 6, 8: begin
          drive(1'b1, (i == 6), (i == 8), 300);
          sb.push_back({mk(IF_NOP, 0, 1'b0, 1'b0, 0), msk(1)});
        end
        default: begin
          drive(1'b0, 1'b0, 1'b0, 0);
          sb.push_back({mk(mem[0], 0, 1'b1, 1'b0, 1), msk(1)});
        end
      endcase
      @(posedge clock); #1;
      e = sb.pop_front(); checks++;
      if (((sample() ^ e.v) & e.m) !== '0) begin
        errors++; $display("FAIL rstmid[%0d] got=%h exp=%h", i, sample(), e.v);
      end
    end
  endtask

  initial begin
    for (int i = 0; i < (1 << AW); i++) mem[i] = 32'h0A00_0000 | DW'(i);
    drive(1'b1, 1'b0, 1'b0, 0);
    test_reset();
    test_fetch();
    test_stall();
    test_branch_stall();
    test_wrap();
    test_halt();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
